// File: rtl/mips_bus_wait_ram_if.sv
// Avalon-style memory bus between mips_cpu_bus (master) and the wait-state RAM (slave).
// Handshake: a request (read or write) is held stable by the master while waitrequest=1;
// the transfer completes in the single cycle where the request is high and waitrequest=0.
interface mips_bus_wait_ram_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_bus_wait_ram.sv
// Two-window byte-addressed RAM slave (data at 0, boot code at INSTR_BASE) that
// inserts WAIT_CYCLES wait states per access so CPU stall paths get exercised.
module mips_bus_wait_ram #(
  parameter int          DATA_BYTES  = 256,
  parameter int          INSTR_BYTES = 256,
  parameter logic [31:0] INSTR_BASE  = 32'hBFC0_0000,
  parameter int          WAIT_CYCLES = 2,
  parameter string       DATA_INIT   = "",
  parameter string       INSTR_INIT  = ""
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_bus_wait_ram_if.slave   bus,
  output logic                 bad_access,
  output logic [1:0]           dbg_state
);

  localparam int DAW = $clog2(DATA_BYTES);
  localparam int IAW = $clog2(INSTR_BYTES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  count, count_nx;

  logic [31:0] lat_addr;
  logic [3:0]  lat_be;
  logic [31:0] lat_wdata;
  logic        lat_rd, lat_wr;

  logic [31:0] rdata_q;
  logic [7:0]  dmem [DATA_BYTES];
  logic [7:0]  imem [INSTR_BYTES];

  logic        req;
  logic        take;
  logic        enter_access;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_be;
  logic        sel_rd, sel_wr;
  logic [31:0] word_addr, i_off;
  logic        misalign, d_hit, i_hit;
  logic [DAW-1:0] d_idx;
  logic [IAW-1:0] i_idx;
  logic [31:0] rd_word;

  // Memory images are not part of reset; they are cleared once at configuration time.
  initial begin
    for (int i = 0; i < DATA_BYTES; i++) dmem[i] = 8'h00;
    for (int i = 0; i < INSTR_BYTES; i++) imem[i] = 8'h00;
  end

  assign req  = bus.read | bus.write;
  assign take = (state == S_IDLE) & req;

  // Held low while reset is asserted so an interrupted transfer releases the CPU at once.
  assign bus.waitrequest = reset & req & (state != S_ACCESS);
  assign bus.readdata    = rdata_q;
  assign dbg_state       = state;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      count <= 4'd0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_nx = S_ACCESS;
            count_nx = 4'd0;
          end else begin
            state_nx = S_WAIT;
            count_nx = 4'(WAIT_CYCLES);
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_nx = S_IDLE;
          count_nx = 4'd0;
        end else if (count <= 4'd1) begin
          state_nx = S_ACCESS;
          count_nx = 4'd0;
        end else begin
          count_nx = count - 4'd1;
        end
      end
      S_ACCESS: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  assign enter_access = (state_nx == S_ACCESS);

  // In IDLE the transaction is being latched this edge, so decode the live bus;
  // afterwards only the latched copy matters.
  always_comb begin
    if (state == S_IDLE) begin
      sel_addr  = bus.address;
      sel_be    = bus.byteenable;
      sel_wdata = bus.writedata;
      sel_rd    = bus.read;
      sel_wr    = bus.write;
    end else begin
      sel_addr  = lat_addr;
      sel_be    = lat_be;
      sel_wdata = lat_wdata;
      sel_rd    = lat_rd;
      sel_wr    = lat_wr;
    end
  end

  // ---------------- window decode ----------------
  assign word_addr = {sel_addr[31:2], 2'b00};
  assign misalign  = |sel_addr[1:0];
  assign i_off     = word_addr - INSTR_BASE;
  assign d_hit     = (word_addr < 32'(DATA_BYTES));
  assign i_hit     = (word_addr >= INSTR_BASE) && (i_off < 32'(INSTR_BYTES));
  assign d_idx     = word_addr[DAW-1:0];
  assign i_idx     = i_off[IAW-1:0];

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (sel_be[i]) begin
        if (d_hit)      rd_word[8*i +: 8] = dmem[d_idx | DAW'(i)];
        else if (i_hit) rd_word[8*i +: 8] = imem[i_idx | IAW'(i)];
      end
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_addr   <= '0;
      lat_be     <= '0;
      lat_wdata  <= '0;
      lat_rd     <= 1'b0;
      lat_wr     <= 1'b0;
      rdata_q    <= '0;
      bad_access <= 1'b0;
    end else begin
      if (take) begin
        lat_addr  <= bus.address;
        lat_be    <= bus.byteenable;
        lat_wdata <= bus.writedata;
        lat_rd    <= bus.read;
        lat_wr    <= bus.write;
      end
      if (enter_access) begin
        rdata_q <= sel_wr ? 32'h0 : rd_word;
        if (misalign || !(d_hit || i_hit) || (sel_rd && sel_wr))
          bad_access <= 1'b1;
      end
    end
  end

  // Writes land at the edge that ends ACCESS; an out-of-window write hits neither array.
  always_ff @(posedge clk) begin
    if (state == S_ACCESS && sel_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_be[i]) begin
          if (d_hit)      dmem[d_idx | DAW'(i)] <= sel_wdata[8*i +: 8];
          else if (i_hit) imem[i_idx | IAW'(i)] <= sel_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mips_bus_wait_ram.sv
// Directed bench for mips_bus_wait_ram: one instance with two wait states and one
// with none, driven by a linear sequence of bus transfers with hand-computed results.
module tb_mips_bus_wait_ram;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_bus_wait_ram_if bus_a ();
  mips_bus_wait_ram_if bus_b ();

  logic       bad_a, bad_b;
  logic [1:0] st_a, st_b;

  mips_bus_wait_ram #(.WAIT_CYCLES(2)) u_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave), .bad_access(bad_a), .dbg_state(st_a)
  );

  mips_bus_wait_ram #(.WAIT_CYCLES(0)) u_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave), .bad_access(bad_b), .dbg_state(st_b)
  );

  int          n_eval = 0;
  int          n_fail = 0;
  logic [31:0] rd;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_eval++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit b, input logic r, input logic w, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    if (b) begin
      bus_b.read = r; bus_b.write = w; bus_b.address = addr;
      bus_b.byteenable = be; bus_b.writedata = wd;
    end else begin
      bus_a.read = r; bus_a.write = w; bus_a.address = addr;
      bus_a.byteenable = be; bus_a.writedata = wd;
    end
  endtask

  task automatic idle(input bit b);
    drive(b, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  // Counts waitrequest cycles of the request already on the bus, captures readdata in
  // the ACCESS cycle, then drops the request right after the completing edge.
  task automatic finish(input bit b, input int exp_wait, input string tag,
                        output logic [31:0] rdata);
    int  n;
    bit  done;
    logic wr;
    n = 0; done = 0; rdata = 32'hx;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      wr = b ? bus_b.waitrequest : bus_a.waitrequest;
      if (wr) begin
        n++;
        @(posedge clk); #1;
      end else begin
        rdata = b ? bus_b.readdata : bus_a.readdata;
        done  = 1;
      end
    end
    chk({tag, "_wait"}, 32'(n), 32'(exp_wait));
    @(posedge clk); #1;
    idle(b);
  endtask

  task automatic xfer(input bit b, input logic r, input logic w, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd, input int exp_wait,
                      input string tag, output logic [31:0] rdata);
    drive(b, r, w, addr, be, wd);
    finish(b, exp_wait, tag, rdata);
  endtask

  task automatic pulse_reset;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b0;
    idle(0); idle(1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wait",  32'(bus_a.waitrequest), 32'h0);
    chk("rst_rdata", bus_a.readdata, 32'h0);
    chk("rst_bad",   32'(bad_a), 32'h0);
    chk("rst_state", 32'(st_a), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // boot word: write then read at the reset vector, three wait cycles each
    xfer(0, 0, 1, 32'hBFC0_0000, 4'hF, 32'h3C08_ABCD, 3, "boot_wr", rd);
    xfer(0, 1, 0, 32'hBFC0_0000, 4'hF, 32'h0, 3, "boot_rd", rd);
    chk("boot_rdata", rd, 32'h3C08_ABCD);

    // partial-lane write, full and partial reads
    xfer(0, 0, 1, 32'h10, 4'b0101, 32'hDEAD_BEEF, 3, "pw_wr", rd);
    xfer(0, 1, 0, 32'h10, 4'hF, 32'h0, 3, "pw_rd", rd);
    chk("pw_rdata", rd, 32'h00AD_00EF);
    xfer(0, 1, 0, 32'h10, 4'b0011, 32'h0, 3, "lane_rd", rd);
    chk("lane_rdata", rd, 32'h0000_00EF);
    xfer(0, 0, 1, 32'h10, 4'b0000, 32'hFFFF_FFFF, 3, "nop_wr", rd);
    xfer(0, 1, 0, 32'h10, 4'hF, 32'h0, 3, "nop_rd", rd);
    chk("nop_rdata", rd, 32'h00AD_00EF);

    // top words of both windows
    xfer(0, 0, 1, 32'hFC, 4'hF, 32'h1122_3344, 3, "dtop_wr", rd);
    xfer(0, 0, 1, 32'hBFC0_00FC, 4'hF, 32'hCAFE_F00D, 3, "itop_wr", rd);
    xfer(0, 1, 0, 32'hFC, 4'hF, 32'h0, 3, "dtop_rd", rd);
    chk("dtop_rdata", rd, 32'h1122_3344);
    xfer(0, 1, 0, 32'hBFC0_00FC, 4'hF, 32'h0, 3, "itop_rd", rd);
    chk("itop_rdata", rd, 32'hCAFE_F00D);

    // bus changes while stalled are ignored
    drive(0, 0, 1, 32'h20, 4'hF, 32'hA5A5_A5A5);
    @(posedge clk); #1;
    drive(0, 0, 1, 32'h24, 4'b0001, 32'h1234_5678);
    @(negedge clk);
    chk("chg_state", 32'(st_a), 32'h1);
    @(posedge clk); #1;
    finish(0, 1, "chg_wr", rd);
    xfer(0, 1, 0, 32'h20, 4'hF, 32'h0, 3, "chg_rd20", rd);
    chk("chg_rdata20", rd, 32'hA5A5_A5A5);
    xfer(0, 1, 0, 32'h24, 4'hF, 32'h0, 3, "chg_rd24", rd);
    chk("chg_rdata24", rd, 32'h0);

    // aborted read, then aborted write that must not commit
    drive(0, 1, 0, 32'h20, 4'hF, 32'h0);
    @(posedge clk); #1;
    idle(0);
    @(negedge clk);
    chk("abort_wait", 32'(bus_a.waitrequest), 32'h0);
    @(negedge clk);
    chk("abort_state", 32'(st_a), 32'h0);
    drive(0, 0, 1, 32'h28, 4'hF, 32'h7777_7777);
    @(posedge clk); #1;
    idle(0);
    repeat (2) @(posedge clk);
    #1;
    xfer(0, 1, 0, 32'h28, 4'hF, 32'h0, 3, "abw_rd", rd);
    chk("abw_rdata", rd, 32'h0);
    chk("good_bad", 32'(bad_a), 32'h0);

    // out-of-window read sets the sticky flag; the next good read still completes
    xfer(0, 1, 0, 32'h0000_1000, 4'hF, 32'h0, 3, "oow_rd", rd);
    chk("oow_rdata", rd, 32'h0);
    chk("oow_bad", 32'(bad_a), 32'h1);
    xfer(0, 1, 0, 32'h10, 4'hF, 32'h0, 3, "after_rd", rd);
    chk("after_rdata", rd, 32'h00AD_00EF);
    chk("sticky_bad", 32'(bad_a), 32'h1);

    // reset in the middle of a write
    drive(0, 0, 1, 32'h10, 4'hF, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("mrst_wait",  32'(bus_a.waitrequest), 32'h0);
    chk("mrst_rdata", bus_a.readdata, 32'h0);
    chk("mrst_bad",   32'(bad_a), 32'h0);
    idle(0);
    @(posedge clk); #1;
    reset = 1'b1;
    xfer(0, 1, 0, 32'h10, 4'hF, 32'h0, 3, "keep_rd", rd);
    chk("keep_rdata", rd, 32'h00AD_00EF);
    xfer(0, 1, 0, 32'hBFC0_0000, 4'hF, 32'h0, 3, "keepi_rd", rd);
    chk("keepi_rdata", rd, 32'h3C08_ABCD);
    chk("keep_bad", 32'(bad_a), 32'h0);

    // misaligned read uses the word address
    xfer(0, 1, 0, 32'h12, 4'hF, 32'h0, 3, "mis_rd", rd);
    chk("mis_rdata", rd, 32'h00AD_00EF);
    chk("mis_bad", 32'(bad_a), 32'h1);

    // read and write together: write wins
    pulse_reset();
    xfer(0, 1, 1, 32'h30, 4'hF, 32'h0BAD_F00D, 3, "rw_wr", rd);
    chk("rw_bad", 32'(bad_a), 32'h1);
    xfer(0, 1, 0, 32'h30, 4'hF, 32'h0, 3, "rw_rd", rd);
    chk("rw_rdata", rd, 32'h0BAD_F00D);

    // one word past each window top
    pulse_reset();
    xfer(0, 1, 0, 32'h100, 4'hF, 32'h0, 3, "dpast_rd", rd);
    chk("dpast_rdata", rd, 32'h0);
    chk("dpast_bad", 32'(bad_a), 32'h1);
    pulse_reset();
    xfer(0, 1, 0, 32'hBFC0_0100, 4'hF, 32'h0, 3, "ipast_rd", rd);
    chk("ipast_rdata", rd, 32'h0);
    chk("ipast_bad", 32'(bad_a), 32'h1);

    // zero-wait instance: back-to-back reads, one waitrequest cycle each
    xfer(1, 0, 1, 32'h0, 4'hF, 32'h1111_1111, 1, "z_wr0", rd);
    xfer(1, 0, 1, 32'h4, 4'hF, 32'h2222_2222, 1, "z_wr4", rd);
    xfer(1, 1, 0, 32'h0, 4'hF, 32'h0, 1, "z_rd0", rd);
    chk("z_rdata0", rd, 32'h1111_1111);
    drive(1, 1, 0, 32'h4, 4'hF, 32'h0);
    @(negedge clk);
    chk("z_bubble_state", 32'(st_b), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("z_rd4_wait", 32'(bus_b.waitrequest), 32'h0);
    chk("z_rdata4", bus_b.readdata, 32'h2222_2222);
    @(posedge clk); #1;
    idle(1);
    chk("z_bad", 32'(bad_b), 32'h0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
